// File: rtl/ndn_pkg.sv
// Shared definitions for the NDN content store: default widths and the
// burst arbiter state encoding.
package ndn_pkg;

  localparam int NDN_ADDR_W = 10;
  localparam int NDN_BYTE_W = 10;
  localparam int NDN_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/ndn_rr_arb2.sv
// Two-requester round-robin picker. A tie goes to the port that did not win
// last time; the remembered winner only updates when en is high.
module ndn_rr_arb2
  import ndn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic en,
  output logic grant_wr,
  output logic grant_rd
);

  grant_t last_grant;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (req_wr && req_rd) begin
      if (last_grant == GNT_READ) grant_wr = 1'b1;
      else                        grant_rd = 1'b1;
    end else if (req_wr) begin
      grant_wr = 1'b1;
    end else if (req_rd) begin
      grant_rd = 1'b1;
    end
  end

  // Reset to READ so the writer wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_READ;
    end else if (en && (grant_wr || grant_rd)) begin
      last_grant <= grant_rd ? GNT_READ : GNT_WRITE;
    end
  end

endmodule

// File: rtl/ndn_ram_arbiter.sv
// Shares the single-port content RAM between the PIT write path and the user
// read path: whole bursts, round-robin, one byte per cycle.
//
// Handshake: a requester raises *_req with addr/len stable and holds it until
// its *_done pulse. Addr and len are captured at grant, so later changes,
// and dropping req mid-burst, have no effect. wr_take marks the cycle in
// which wr_data is consumed; rd_valid marks a byte on rd_data.
module ndn_ram_arbiter
  import ndn_pkg::*;
#(
  parameter int ADDR_W  = NDN_ADDR_W,
  parameter int BYTE_W  = NDN_BYTE_W,
  parameter int DATA_W  = NDN_DATA_W,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_take,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_len,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_byte,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        dbg_state
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] len_q;
  logic [BYTE_W-1:0] cnt_q;
  logic              rd_valid_q;
  logic              grant_wr, grant_rd;
  logic              len_zero;
  logic              last_beat;

  function automatic logic [BYTE_W-1:0] clamp_len(input logic [BYTE_W-1:0] len);
    return (len > BYTE_W'(MAX_LEN)) ? BYTE_W'(MAX_LEN) : len;
  endfunction

  ndn_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_wr   (wr_req),
    .req_rd   (rd_req),
    .en       (state == ST_IDLE),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  assign len_zero  = (len_q == '0);
  assign last_beat = (cnt_q == len_q - BYTE_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= (state == ST_READ) && !len_zero;
      if (state == ST_IDLE) begin
        cnt_q <= '0;
        if (grant_wr) begin
          addr_q <= wr_addr;
          len_q  <= clamp_len(wr_len);
        end else if (grant_rd) begin
          addr_q <= rd_addr;
          len_q  <= clamp_len(rd_len);
        end
      end else if ((state == ST_WRITE || state == ST_READ) && !len_zero) begin
        cnt_q <= cnt_q + BYTE_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wr_take   = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_byte  = '0;
    ram_data  = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant_wr)      state_nxt = ST_WRITE;
        else if (grant_rd) state_nxt = ST_READ;
      end
      ST_WRITE: begin
        if (len_zero) begin
          wr_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          ram_we   = 1'b1;
          ram_addr = addr_q;
          ram_byte = cnt_q;
          ram_data = wr_data;
          wr_take  = 1'b1;
          if (last_beat) begin
            wr_done   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (len_zero) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          ram_addr = addr_q;
          ram_byte = cnt_q;
          if (last_beat) state_nxt = ST_DRAIN;
        end
      end
      // Last read byte arrives here, one cycle behind its address.
      ST_DRAIN: begin
        rd_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ndn_ram_arbiter.sv
// Directed bench for ndn_ram_arbiter with a behavioural RAM and a
// queue-based scoreboard checked by an independent monitor.
module tb_ndn_ram_arbiter;

  localparam int ADDR_W  = 10;
  localparam int BYTE_W  = 10;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 64;

  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [BYTE_W-1:0] wr_len = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_take, wr_done;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [BYTE_W-1:0] rd_len = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_done, busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_byte;
  logic              ram_we;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic [1:0]        dbg_state;

  ndn_ram_arbiter #(
    .ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_take(wr_take), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .busy(busy), .ram_addr(ram_addr), .ram_byte(ram_byte), .ram_we(ram_we),
    .ram_data(ram_data), .ram_q(ram_q), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural RAM (1-cycle read latency) ----------------
  logic [DATA_W-1:0] ram_mem [int];
  always @(posedge clk) begin
    int k;
    k = int'({ram_addr, ram_byte});
    ram_q <= ram_mem.exists(k) ? ram_mem[k] : '0;
    if (ram_we) ram_mem[k] = ram_data;
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  logic busy_prev = 1'b0;

  // {take, done, we, addr, byte, data}
  logic [2+ADDR_W+BYTE_W+DATA_W:0] exp_wr_q[$];
  // {valid, done, data}
  logic [DATA_W+1:0]               exp_rd_q[$];
  logic [1:0]                      exp_gnt_q[$];
  logic [DATA_W-1:0]               mem_model [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name, input logic [63:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
  endtask

  function automatic logic [DATA_W-1:0] model_get(input logic [ADDR_W-1:0] a, input int i);
    int k;
    k = int'({a, BYTE_W'(i)});
    return mem_model.exists(k) ? mem_model[k] : '0;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    logic [2+ADDR_W+BYTE_W+DATA_W:0] aw;
    logic [DATA_W+1:0] ar;
    if (rst) begin
      if (busy) busy_cnt++;
      if (wr_take || wr_done) begin
        aw = {wr_take, wr_done, ram_we, ram_addr, ram_byte, ram_data};
        if (exp_wr_q.size() == 0) missing("wr_beat", 64'(aw));
        else check("wr_beat", 64'(aw), 64'(exp_wr_q.pop_front()));
      end
      if (rd_valid || rd_done) begin
        ar = {rd_valid, rd_done, rd_data};
        if (exp_rd_q.size() == 0) missing("rd_beat", 64'(ar));
        else check("rd_beat", 64'(ar), 64'(exp_rd_q.pop_front()));
      end
      if (busy && !busy_prev) begin
        if (exp_gnt_q.size() == 0) missing("grant", 64'(dbg_state));
        else check("grant", 64'(dbg_state), 64'(exp_gnt_q.pop_front()));
      end
    end
    busy_prev = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [BYTE_W-1:0] n,
                          input logic [DATA_W-1:0] base, input int drop_after);
    int lc;
    int took;
    int budget;
    logic done;
    lc = (n > BYTE_W'(MAX_LEN)) ? MAX_LEN : int'(n);
    if (lc == 0) exp_wr_q.push_back({1'b0, 1'b1, 1'b0, ADDR_W'(0), BYTE_W'(0), DATA_W'(0)});
    for (int i = 0; i < lc; i++) begin
      exp_wr_q.push_back({1'b1, (i == lc - 1), 1'b1, a, BYTE_W'(i), DATA_W'(int'(base) + i)});
      mem_model[int'({a, BYTE_W'(i)})] = DATA_W'(int'(base) + i);
    end
    took = 0; budget = 0; done = 1'b0;
    wr_addr = a; wr_len = n; wr_data = base; wr_req = 1'b1;
    while (!done && budget < 400) begin
      @(negedge clk);
      budget++;
      if (wr_take) took++;
      done = wr_done;
      @(posedge clk);
      #1;
      wr_data = DATA_W'(int'(base) + took);
      if (done || (drop_after > 0 && took >= drop_after)) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    if (!done) missing("wr_timeout", 64'(took));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [BYTE_W-1:0] n);
    int lc;
    int budget;
    logic done;
    lc = (n > BYTE_W'(MAX_LEN)) ? MAX_LEN : int'(n);
    if (lc == 0) exp_rd_q.push_back({1'b0, 1'b1, DATA_W'(0)});
    for (int i = 0; i < lc; i++)
      exp_rd_q.push_back({1'b1, (i == lc - 1), model_get(a, i)});
    budget = 0; done = 1'b0;
    rd_addr = a; rd_len = n; rd_req = 1'b1;
    while (!done && budget < 400) begin
      @(negedge clk);
      budget++;
      done = rd_done;
      @(posedge clk);
      #1;
    end
    rd_req = 1'b0;
    if (!done) missing("rd_timeout", 64'(budget));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0;
    int took;
    int budget;

    // Reset state: everything low while rst is held.
    wr_req = 1'b1; wr_len = 10'd4; wr_data = 8'h5A;
    #12;
    check("reset_outs", 64'({wr_take, wr_done, rd_valid, rd_done, busy, ram_we}), 64'(0));
    check("reset_bus", 64'({ram_addr, ram_byte, ram_data, rd_data}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests right after reset: writer first.
    exp_gnt_q.push_back(S_WRITE);
    exp_gnt_q.push_back(S_READ);
    fork
      do_write(10'd1, 10'd2, 8'h11, 0);
      do_read(10'd2, 10'd2);
    join
    @(posedge clk); #1;

    // Write 4 bytes to entry 5, read them back; busy spans N and N+1 cycles.
    exp_gnt_q.push_back(S_WRITE);
    b0 = busy_cnt;
    do_write(10'd5, 10'd4, 8'hA0, 0);
    check("wr_busy_cycles", 64'(busy_cnt - b0), 64'(4));
    exp_gnt_q.push_back(S_READ);
    b0 = busy_cnt;
    do_read(10'd5, 10'd4);
    check("rd_busy_cycles", 64'(busy_cnt - b0), 64'(5));
    @(posedge clk); #1;

    // Both held across two bursts each: W,R,W,R.
    exp_gnt_q.push_back(S_WRITE);
    exp_gnt_q.push_back(S_READ);
    exp_gnt_q.push_back(S_WRITE);
    exp_gnt_q.push_back(S_READ);
    fork
      begin
        do_write(10'd6, 10'd3, 8'h60, 0);
        do_write(10'd7, 10'd2, 8'h70, 0);
      end
      begin
        do_read(10'd5, 10'd2);
        do_read(10'd5, 10'd3);
      end
    join
    @(posedge clk); #1;

    // Zero length on each port.
    exp_gnt_q.push_back(S_WRITE);
    do_write(10'd4, 10'd0, 8'h00, 0);
    @(posedge clk); #1;
    exp_gnt_q.push_back(S_READ);
    do_read(10'd4, 10'd0);
    @(posedge clk); #1;

    // Clamp: 100-byte requests run exactly 64 beats.
    exp_gnt_q.push_back(S_WRITE);
    do_write(10'd3, 10'd100, 8'h00, 0);
    exp_gnt_q.push_back(S_READ);
    do_read(10'd3, 10'd100);
    @(posedge clk); #1;

    // Mid-burst reset: prefill entry 9, then abort an overwrite during beat 2.
    exp_gnt_q.push_back(S_WRITE);
    do_write(10'd9, 10'd8, 8'hB0, 0);
    exp_gnt_q.push_back(S_WRITE);
    for (int i = 0; i < 2; i++) begin
      exp_wr_q.push_back({1'b1, 1'b0, 1'b1, ADDR_W'(9), BYTE_W'(i), DATA_W'(8'hC0 + i)});
      mem_model[int'({ADDR_W'(9), BYTE_W'(i)})] = DATA_W'(8'hC0 + i);
    end
    wr_addr = 10'd9; wr_len = 10'd8; wr_data = 8'hC0; wr_req = 1'b1;
    took = 0; budget = 0;
    while (took < 2 && budget < 50) begin
      @(negedge clk);
      budget++;
      if (wr_take) took++;
      @(posedge clk); #1;
      wr_data = DATA_W'(8'hC0 + took);
    end
    if (took < 2) missing("abort_timeout", 64'(took));
    #2;
    rst = 1'b0;
    #1;
    check("abort_we", 64'(ram_we), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'({wr_take, wr_done}), 64'(0));
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_gnt_q.push_back(S_READ);
    do_read(10'd9, 10'd8);
    @(posedge clk); #1;

    // Request dropped after one beat: burst still completes.
    exp_gnt_q.push_back(S_WRITE);
    do_write(10'd10, 10'd3, 8'hD0, 1);
    exp_gnt_q.push_back(S_READ);
    do_read(10'd10, 10'd3);

    repeat (5) @(posedge clk);
    #1;
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
    check("gnt_q_empty", 64'(exp_gnt_q.size()), 64'(0));
    check("idle_at_end", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ndn_ram_arbiter.md
Name: ndn_ram_arbiter

Overview:
- Shares the single-port content RAM between two burst requesters: the PIT write path, which stores returning data bytes, and the user read path, which replays stored content.
- Sits between the PIT/user logic and the RAM, and owns the RAM address, byte offset, write-enable and data inputs.
- Grants whole bursts with round-robin fairness and sequences one byte per cycle.
- Hides the RAM's 1-cycle read latency behind a valid strobe.

Parameters:
- ADDR_W, 10, RAM entry address width (one entry per PIT table slot)
- BYTE_W, 10, byte-offset width within an entry; also the width of burst length
- DATA_W, 8, RAM data width
- MAX_LEN, 64, maximum burst length in bytes; larger requests are clamped

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_req  in  1  writer requests a burst; held until wr_done
- wr_addr  in  ADDR_W  entry to write
- wr_len  in  BYTE_W  bytes to write
- wr_data  in  DATA_W  byte for the current beat
- wr_take  out  1  current wr_data is written this cycle; writer advances
- wr_done  out  1  one-cycle pulse with the last write beat
- rd_req  in  1  reader requests a burst; held until rd_done
- rd_addr  in  ADDR_W  entry to read
- rd_len  in  BYTE_W  bytes to read
- rd_data  out  DATA_W  read byte
- rd_valid  out  1  rd_data is valid
- rd_done  out  1  one-cycle pulse with the last rd_valid
- busy  out  1  a burst is in progress
- ram_addr  out  ADDR_W  to RAM addr
- ram_byte  out  BYTE_W  to RAM byte offset
- ram_we  out  1  to RAM write enable
- ram_data  out  DATA_W  to RAM data
- ram_q  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; counters and latched address/length cleared.
  - All outputs 0, including ram_we, immediately.
  - last_grant = READ, so the writer wins the first tie.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - Only wr_req -> WRITE. Only rd_req -> READ.
  - Both -> the port that did not hold last_grant.
  - On entry: latch addr; latch len clamped to MAX_LEN; cnt=0; update last_grant.
  - busy=1 from the cycle after the grant.
- Zero length: req with len=0 is granted, makes no RAM access, and the port's done pulses on the cycle after the grant.
  - The writer gets no wr_take.
  - The reader gets rd_done without rd_valid.
  - Return to IDLE.
- WRITE, each cycle:
  - ram_we=1, ram_addr=latched addr, ram_byte=cnt.
  - ram_data=wr_data (combinational pass-through); wr_take=1.
  - cnt++.
  - On cnt==len-1: wr_done=1 in that cycle, next state IDLE.
- READ, each cycle:
  - ram_we=0, ram_addr=latched addr, ram_byte=cnt; cnt++.
  - On cnt==len-1: next state DRAIN.
- Read data path:
  - rd_valid is the READ-state flag registered one cycle; rd_data = ram_q, so each beat arrives 1 cycle after its address.
  - DRAIN: no RAM access; presents the last byte with rd_valid=1 and rd_done=1, then IDLE.
- Between bursts:
  - At least one IDLE cycle always separates consecutive bursts, and arbitration happens only in IDLE.
  - Outside WRITE, ram_we=0 and ram_data=0.
- Request deassertion mid-burst is ignored; the burst completes with the latched length.
- Address and length changes after the grant are ignored.
- A new req on the owning port during its own burst is not seen until IDLE.
- Counter width BYTE_W, so no wrap is possible: cnt never exceeds MAX_LEN-1 < 2^BYTE_W.
- Reset asserted mid-burst aborts the burst. No done pulse is issued and any partial RAM contents remain.
- Throughput:
  - Write burst of N: N+1 cycles including IDLE.
  - Read burst of N: N+2 cycles.

Decomposition:
- Shared package ndn_pkg holds:
  - state encoding constants (ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN)
  - ADDR_W, BYTE_W and DATA_W defaults, shared with the RAM and PIT
- One natural sub-module: ndn_rr_arb2, the 2-requester round-robin picker with last_grant state.
- The burst FSM and counter stay in the top module.

Test Plan:
1. Write burst, then read it back:
   - wr_req, wr_addr=5, wr_len=4, bytes A0..A3 -> wr_take on 4 consecutive cycles, ram_byte 0..3, wr_done on the 4th.
   - Then rd_req, addr=5, len=4 -> rd_valid 4 cycles with A0..A3, rd_done on the A3 beat.
2. Simultaneous requests:
   - wr_req and rd_req in the same cycle right after reset -> writer granted first, then the reader.
   - Repeat with both requests held -> grants alternate W,R,W,R.
3. Zero length:
   - wr_len=0 -> wr_done 1 cycle after the grant, no ram_we.
   - rd_len=0 -> rd_done with no rd_valid.
4. Clamp:
   - rd_len=100 with MAX_LEN=64 -> exactly 64 rd_valid beats, ram_byte 0..63.
5. Mid-burst reset:
   - rst low during beat 2 of an 8-byte write -> ram_we drops immediately, busy=0, no wr_done.
   - After release, a fresh read of the same entry returns bytes 0..1 written and later bytes unchanged.
6. Request drop:
   - wr_req deasserted after 1 beat of a 3-byte burst -> 3 wr_take beats and wr_done still occur.
